// File: rtl/qam_mapper.sv
// Unpacks 32-bit coded-bit words into a bit buffer and maps bps-bit groups to
// Gray-coded BPSK/QPSK/16QAM/64QAM samples {Im,Re} in Q1.15, one burst per frame.
module qam_mapper #(
    parameter int          BUF_W = 64,
    parameter logic [15:0] LVL_Q = 16'h5A82
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic [1:0]  MOD
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_reg;
    logic [BUF_W-1:0]   buf_reg;
    logic [CNT_W-1:0]   buf_cnt_reg;
    logic [1:0]         mod_reg;
    logic [1:0]         mod_pend_reg;
    logic               cyc_d_reg;
    logic               rise_pend_reg;
    logic [31:0]        dat_o_reg;
    logic               stb_o_reg;
    logic               cyc_o_reg;

    logic [CNT_W-1:0]   bps;
    logic               cyc_rise;
    logic               accept;
    logic               take;
    logic [BUF_W-1:0]   buf_app;
    logic [BUF_W-1:0]   buf_next;
    logic [CNT_W-1:0]   cnt_next;

    function automatic logic [15:0] neg16(input logic [15:0] x);
        return 16'd0 - x;
    endfunction

    // Two-bit axis code {msb,lsb}: lsb selects inner/outer ring, msb the sign.
    function automatic logic [15:0] lvl16(input logic msb, input logic lsb);
        logic [15:0] mag;
        mag = lsb ? 16'h2AAA : 16'h7FFF;
        return msb ? mag : neg16(mag);
    endfunction

    function automatic logic [15:0] lvl64(input logic a, input logic b, input logic c);
        logic [15:0] mag;
        case ({b, c})
            2'b00:   mag = 16'h7FFF;
            2'b01:   mag = 16'h5B6D;
            2'b11:   mag = 16'h36DB;
            default: mag = 16'h1249;
        endcase
        return a ? mag : neg16(mag);
    endfunction

    function automatic logic [31:0] map_symbol(input logic [5:0] s, input logic [1:0] m);
        logic [15:0] re;
        logic [15:0] im;
        case (m)
            2'b00: begin
                re = s[0] ? 16'h8001 : 16'h7FFF;
                im = 16'h0000;
            end
            2'b01: begin
                re = s[0] ? neg16(LVL_Q) : LVL_Q;
                im = s[1] ? neg16(LVL_Q) : LVL_Q;
            end
            2'b10: begin
                re = lvl16(s[0], s[1]);
                im = lvl16(s[2], s[3]);
            end
            default: begin
                re = lvl64(s[0], s[1], s[2]);
                im = lvl64(s[3], s[4], s[5]);
            end
        endcase
        return {im, re};
    endfunction

    always_comb begin
        case (mod_reg)
            2'b00:   bps = CNT_W'(1);
            2'b01:   bps = CNT_W'(2);
            2'b10:   bps = CNT_W'(4);
            default: bps = CNT_W'(6);
        endcase
    end

    assign cyc_rise = CYC_I & ~cyc_d_reg;
    assign accept   = CYC_I & STB_I & WE_I & (buf_cnt_reg <= CNT_W'(BUF_W - 32)) & (state_reg == RUN);
    assign take     = (state_reg == RUN) & (buf_cnt_reg >= bps) & (~stb_o_reg | ACK_I);

    // Bits above buf_cnt are kept zero, so appending is a plain OR.
    always_comb begin
        buf_app  = buf_reg;
        cnt_next = buf_cnt_reg;
        if (accept) begin
            buf_app  = buf_reg | ({{(BUF_W-32){1'b0}}, DAT_I} << buf_cnt_reg);
            cnt_next = cnt_next + CNT_W'(32);
        end
        buf_next = buf_app;
        if (take) begin
            buf_next = buf_app >> bps;
            cnt_next = cnt_next - bps;
        end
    end

    // cyc_d resets high so a CYC_I held across reset is not taken as a fresh burst.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_reg     <= IDLE;
            buf_reg       <= '0;
            buf_cnt_reg   <= '0;
            mod_reg       <= 2'b00;
            mod_pend_reg  <= 2'b00;
            cyc_d_reg     <= 1'b1;
            rise_pend_reg <= 1'b0;
            dat_o_reg     <= 32'd0;
            stb_o_reg     <= 1'b0;
            cyc_o_reg     <= 1'b0;
        end else begin
            cyc_d_reg <= CYC_I;

            if (take) begin
                dat_o_reg <= map_symbol(buf_reg[5:0], mod_reg);
                stb_o_reg <= 1'b1;
                cyc_o_reg <= 1'b1;
            end else if (ACK_I) begin
                stb_o_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (cyc_rise | rise_pend_reg) begin
                        state_reg     <= RUN;
                        buf_reg       <= '0;
                        buf_cnt_reg   <= '0;
                        mod_reg       <= cyc_rise ? MOD : mod_pend_reg;
                        rise_pend_reg <= 1'b0;
                    end
                end
                RUN: begin
                    buf_reg     <= buf_next;
                    buf_cnt_reg <= cnt_next;
                    if (!CYC_I && (buf_cnt_reg < bps)) begin
                        state_reg   <= FLUSH;
                        buf_reg     <= '0;
                        buf_cnt_reg <= '0;
                    end
                end
                FLUSH: begin
                    if (cyc_rise) begin
                        rise_pend_reg <= 1'b1;
                        mod_pend_reg  <= MOD;
                    end
                    if (!stb_o_reg) begin
                        cyc_o_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ACK_O = accept;
    assign DAT_O = dat_o_reg;
    assign STB_O = stb_o_reg;
    assign WE_O  = stb_o_reg;
    assign CYC_O = cyc_o_reg;

endmodule

// File: tb/tb_qam_mapper.sv
// Scoreboard bench for qam_mapper: expected samples are derived from the driven
// bits by a table-based reference mapper and compared as the DUT emits them.
module tb_qam_mapper;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [31:0] DAT_I = 32'd0;
    logic        CYC_I = 1'b0;
    logic        STB_I = 1'b0;
    logic        WE_I  = 1'b0;
    logic        ACK_I = 1'b1;
    logic [1:0]  MOD   = 2'b00;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] obs_q[$];
    bit          sb_en = 1'b1;
    bit          burst_busy = 1'b0;
    logic [31:0] wbuf[4];
    logic [31:0] mon_exp;

    always #5 CLK_I = ~CLK_I;

    qam_mapper #(.BUF_W(64), .LVL_Q(16'h5A82)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
        .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
        .WE_O(WE_O), .ACK_I(ACK_I), .MOD(MOD)
    );

    function automatic logic [15:0] ref_ax16(input logic [1:0] code);
        case (code)
            2'b00:   return 16'h8001;
            2'b01:   return 16'hD556;
            2'b11:   return 16'h2AAA;
            default: return 16'h7FFF;
        endcase
    endfunction

    function automatic logic [15:0] ref_ax64(input logic [2:0] code);
        case (code)
            3'b000:  return 16'h8001;
            3'b001:  return 16'hA493;
            3'b011:  return 16'hC925;
            3'b010:  return 16'hEDB7;
            3'b110:  return 16'h1249;
            3'b111:  return 16'h36DB;
            3'b101:  return 16'h5B6D;
            default: return 16'h7FFF;
        endcase
    endfunction

    // s[0] is the oldest bit and the MSB of each axis code.
    function automatic logic [31:0] ref_map(input logic [1:0] m, input logic [5:0] s);
        case (m)
            2'b00:   return {16'h0000, (s[0] ? 16'h8001 : 16'h7FFF)};
            2'b01:   return {(s[1] ? 16'hA57E : 16'h5A82), (s[0] ? 16'hA57E : 16'h5A82)};
            2'b10:   return {ref_ax16({s[2], s[3]}), ref_ax16({s[0], s[1]})};
            default: return {ref_ax64({s[3], s[4], s[5]}), ref_ax64({s[0], s[1], s[2]})};
        endcase
    endfunction

    // Samples are transferred on the next rising edge when STB_O & ACK_I at the falling edge.
    always @(negedge CLK_I) begin
        if (RST_I && STB_O && ACK_I) begin
            obs_q.push_back(DAT_O);
            if (sb_en) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got %h, required no sample", DAT_O);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (DAT_O !== mon_exp || WE_O !== 1'b1) begin
                        errors++;
                        $display("FAIL sample: got %h we=%b, required %h we=1", DAT_O, WE_O, mon_exp);
                    end else begin
                        $display("sample %0d: %h", obs_q.size(), DAT_O);
                    end
                end
            end
        end
    end

    task automatic push_expected(input logic [1:0] m, input int n, output int nsym);
        int bps;
        int k;
        logic [5:0] s;
        bps  = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 6;
        nsym = (32 * n) / bps;
        for (int j = 0; j < nsym; j++) begin
            s = 6'd0;
            for (int i = 0; i < bps; i++) begin
                k = j * bps + i;
                s[i] = wbuf[k / 32][k % 32];
            end
            sb_q.push_back(ref_map(m, s));
        end
    endtask

    task automatic run_burst(input logic [1:0] m, input int n, output int nexp);
        int  t;
        bit  acked;
        bit  seen;
        bit  done;
        burst_busy = 1'b1;
        sb_q.delete();
        obs_q.delete();
        push_expected(m, n, nexp);
        @(posedge CLK_I); #1;
        MOD   = m;
        CYC_I = 1'b1;
        for (int w = 0; w < n; w++) begin
            STB_I = 1'b1;
            WE_I  = 1'b1;
            DAT_I = wbuf[w];
            t = 0;
            acked = 1'b0;
            while (!acked && t < 1000) begin
                @(negedge CLK_I);
                if (ACK_O) acked = 1'b1;
                t++;
            end
            checks++;
            if (!acked) begin
                errors++;
                $display("FAIL ack_timeout: word %0d got no ACK_O, required ACK_O=1", w);
            end
            @(posedge CLK_I); #1;
            MOD = ~m;
        end
        STB_I = 1'b0;
        WE_I  = 1'b0;
        CYC_I = 1'b0;
        DAT_I = 32'd0;
        seen = 1'b0;
        done = 1'b0;
        t = 0;
        while (!done && t < 5000) begin
            @(negedge CLK_I);
            if (CYC_O) seen = 1'b1;
            else if (seen) done = 1'b1;
            t++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cyc_o_drop: got CYC_O=%b after timeout, required 0", CYC_O);
        end
        checks++;
        if (sb_q.size() != 0 || STB_O !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: got %0d samples pending stb=%b, required 0 pending stb=0", sb_q.size(), STB_O);
        end
        $display("burst mod=%0d words=%0d: %0d samples", m, n, obs_q.size());
        burst_busy = 1'b0;
    endtask

    task automatic check_count(input string name, input int required);
        checks++;
        if (obs_q.size() != required) begin
            errors++;
            $display("FAIL %s_count: got %0d, required %0d", name, obs_q.size(), required);
        end
    endtask

    task automatic check_first(input string name, input logic [31:0] required);
        logic [31:0] got;
        got = (obs_q.size() > 0) ? obs_q[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== required) begin
            errors++;
            $display("FAIL %s_first: got %h, required %h", name, got, required);
        end
    endtask

    task automatic test_reset();
        #1 RST_I = 1'b0;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        #2;
        checks++;
        if (DAT_O !== 32'd0 || STB_O !== 1'b0 || CYC_O !== 1'b0 || ACK_O !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got dat=%h stb=%b cyc=%b ack=%b, required all 0", DAT_O, STB_O, CYC_O, ACK_O);
        end
        repeat (3) @(posedge CLK_I);
        #1;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        $display("reset released");
    endtask

    task automatic test_qpsk();
        int n;
        wbuf[0] = 32'h0000_0003;
        run_burst(2'b01, 1, n);
        check_count("qpsk", 16);
        check_first("qpsk", 32'hA57E_A57E);
        checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== 32'h5A82_5A82) begin
            errors++;
            $display("FAIL qpsk_last: got %h, required 5a825a82", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'hx);
        end
    endtask

    task automatic test_bpsk();
        int n;
        wbuf[0] = 32'hAAAA_AAAA;
        run_burst(2'b00, 1, n);
        check_count("bpsk", 32);
        check_first("bpsk", 32'h0000_7FFF);
        checks++;
        if (obs_q.size() < 2 || obs_q[1] !== 32'h0000_8001) begin
            errors++;
            $display("FAIL bpsk_second: got %h, required 00008001", (obs_q.size() > 1) ? obs_q[1] : 32'hx);
        end
    endtask

    task automatic test_16qam();
        int n;
        wbuf[0] = 32'h0000_0001;
        run_burst(2'b10, 1, n);
        check_count("qam16_a", 8);
        check_first("qam16_a", 32'h8001_7FFF);
        wbuf[0] = 32'h0000_0006;
        run_burst(2'b10, 1, n);
        check_first("qam16_b", 32'h7FFF_D556);
    endtask

    task automatic test_64qam();
        int n;
        for (int i = 0; i < 3; i++) wbuf[i] = 32'hFFFF_FFFF;
        run_burst(2'b11, 3, n);
        check_count("qam64_3w", 16);
        check_first("qam64_3w", 32'h36DB_36DB);
        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        run_burst(2'b11, 2, n);
        check_count("qam64_2w", 10);
    endtask

    task automatic test_stall();
        int n;
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        fork
            run_burst(2'b01, 4, n);
            begin : stall_proc
                int t;
                logic [31:0] held;
                t = 0;
                do begin
                    @(negedge CLK_I);
                    t++;
                end while (obs_q.size() < 5 && t < 2000);
                @(posedge CLK_I); #1;
                ACK_I = 1'b0;
                @(negedge CLK_I);
                held = DAT_O;
                for (int c = 0; c < 4; c++) begin
                    @(negedge CLK_I);
                    checks++;
                    if (STB_O !== 1'b1 || DAT_O !== held || ACK_O !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold: got stb=%b dat=%h ack=%b, required stb=1 dat=%h ack=0",
                                 STB_O, DAT_O, ACK_O, held);
                    end
                end
                $display("stall of 5 cycles held %h", held);
                @(posedge CLK_I); #1;
                ACK_I = 1'b1;
            end
        join
        check_count("stall", 64);
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        fork
            run_burst(2'b11, 3, n);
            begin
                @(posedge CLK_I);
                while (burst_busy) begin
                    @(posedge CLK_I); #1;
                    ACK_I = 1'($urandom_range(0, 1));
                end
                ACK_I = 1'b1;
            end
        join
        check_count("backpressure", 16);
    endtask

    task automatic test_reset_midburst();
        int t;
        sb_en = 1'b0;
        @(posedge CLK_I); #1;
        MOD   = 2'b01;
        CYC_I = 1'b1;
        for (int w = 0; w < 2; w++) begin
            STB_I = 1'b1;
            WE_I  = 1'b1;
            DAT_I = $urandom;
            t = 0;
            do begin
                @(negedge CLK_I);
                t++;
            end while (!ACK_O && t < 100);
            @(posedge CLK_I); #1;
        end
        STB_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #2;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        checks++;
        if (STB_O !== 1'b1) begin
            errors++;
            $display("FAIL midburst_active: got STB_O=%b, required 1", STB_O);
        end
        RST_I = 1'b0;
        #1;
        checks++;
        if (DAT_O !== 32'd0 || STB_O !== 1'b0 || CYC_O !== 1'b0 || ACK_O !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got dat=%h stb=%b cyc=%b ack=%b, required all 0", DAT_O, STB_O, CYC_O, ACK_O);
        end
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK_I);
            checks++;
            if (ACK_O !== 1'b0 || STB_O !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got ack=%b stb=%b, required 0 0", ACK_O, STB_O);
            end
        end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        @(posedge CLK_I); #1;
        sb_q.delete();
        sb_en = 1'b1;
        $display("mid-burst reset done");
        test_qpsk();
    endtask

    initial begin
        test_reset();
        test_qpsk();
        test_bpsk();
        test_16qam();
        test_64qam();
        test_stall();
        test_backpressure();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
